fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation RISC-V core.
- Replaces the direct PC-to-instruction-memory path with a request/grant memory interface and an in-order prefetch queue of depth DEPTH.
- Supports branch/jump redirect with queue flush and discard of in-flight responses.
- Sits between the PC/redirect logic and the decode stage; presents one instruction plus its PC per valid/ready handshake.

---
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fetch_queue                                                |
// | Brief   : Instruction-fetch front end. It issues requests on a       |
// |           request/grant memory port and keeps an in-order prefetch   |
// |           queue. Redirects flush the queue and drop stale responses. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module fetch_queue #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            i_clk,
   input  logic            i_rst,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [XLEN-1:0] i_imem_rdata,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_insn_valid,
   output logic [XLEN-1:0] o_insn,
   output logic [XLEN-1:0] o_insn_pc,
   input  logic            i_insn_ready,
   output logic [XLEN-1:0] o_fetch_pc
);

   localparam int unsigned   CW      = $clog2(DEPTH + 1);
   localparam int unsigned   PW      = $clog2(DEPTH);
   localparam logic [CW:0]   C_DEPTH = (CW + 1)'(DEPTH);
   localparam logic [PW-1:0] C_LAST  = PW'(DEPTH - 1);
   localparam logic [XLEN-1:0] C_STEP = XLEN'(4);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

   logic [XLEN-1:0] insn_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_q   [DEPTH];

   logic [CW:0]     credit_sum;
   logic            req;
   logic            grant;
   logic            push;
   logic            pop;
   logic [CW-1:0]   outst_next;
   logic [XLEN-1:0] redirect_aligned;
   logic            w_unused_redir_lsb;

   // Handshake decode: credits cover queued entries plus fetches in flight.
   always_comb begin
      credit_sum       = {1'b0, count_q} + {1'b0, outst_q};
      // Gating with the reset input keeps the request low while reset is held.
      req              = i_rst && !i_redirect_valid && (credit_sum < C_DEPTH);
      grant            = req && i_imem_gnt;
      o_insn_valid     = (count_q != '0) && !i_redirect_valid;
      pop              = o_insn_valid && i_insn_ready;
      push             = i_imem_rvalid && !i_redirect_valid && (discard_q == '0);
      outst_next       = outst_q + CW'(grant) - CW'(i_imem_rvalid);
      redirect_aligned = {i_redirect_pc[XLEN-1:2], 2'b00};
   end

   assign w_unused_redir_lsb = ^i_redirect_pc[1:0];

   assign o_imem_req  = req;
   assign o_imem_addr = fetch_pc_q;
   assign o_fetch_pc  = fetch_pc_q;
   assign o_insn      = insn_mem_q[rd_ptr_q];
   assign o_insn_pc   = pc_mem_q[rd_ptr_q];

   // Next-state: a redirect flushes everything and marks in-flight data stale.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      count_d    = count_q;
      outst_d    = outst_next;
      discard_d  = discard_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (i_redirect_valid) begin
         fetch_pc_d = redirect_aligned;
         resp_pc_d  = redirect_aligned;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         discard_d  = outst_next;
      end else begin
         if (grant) begin
            fetch_pc_d = fetch_pc_q + C_STEP;
         end
         if (i_imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + C_STEP;
            wr_ptr_d  = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Control state registers with asynchronous active-low reset.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         count_q    <= '0;
         outst_q    <= '0;
         discard_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Queue storage; contents are qualified by count, so no reset is needed.
   always_ff @(posedge i_clk) begin
      if (push) begin
         insn_mem_q[wr_ptr_q] <= i_imem_rdata;
         pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fetch_queue                                             |
// | Brief   : Directed self-checking bench for fetch_queue with an       |
// |           in-order memory model of configurable latency.             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        redir;
   logic [31:0] redir_pc;
   logic        insn_valid;
   logic [31:0] insn;
   logic [31:0] insn_pc;
   logic        ready;
   logic [31:0] fetch_pc;

   int          n_chk  = 0;
   int          n_fail = 0;
   int          cyc    = 0;
   int          lat    = 1;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];

   fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .i_clk            (clk),
      .i_rst            (rst_n),
      .o_imem_req       (req),
      .o_imem_addr      (addr),
      .i_imem_gnt       (gnt),
      .i_imem_rvalid    (rvalid),
      .i_imem_rdata     (rdata),
      .i_redirect_valid (redir),
      .i_redirect_pc    (redir_pc),
      .o_insn_valid     (insn_valid),
      .o_insn           (insn),
      .o_insn_pc        (insn_pc),
      .i_insn_ready     (ready),
      .o_fetch_pc       (fetch_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] dat(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   // In-order memory: head response returns once its due cycle is reached.
   task automatic drive_mem();
      rvalid = 1'b0;
      rdata  = '0;
      if (pend_addr.size() > 0) begin
         if (pend_due[0] <= cyc) begin
            rvalid = 1'b1;
            rdata  = dat(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   // Called at the negedge: record a grant, advance to just after the next edge.
   task automatic to_next();
      if (req === 1'b1 && gnt === 1'b1) begin
         pend_addr.push_back(addr);
         pend_due.push_back(cyc + lat);
      end
      @(posedge clk);
      #1;
      cyc++;
      drive_mem();
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      pend_addr.delete();
      pend_due.delete();
      rvalid   = 1'b0;
      rdata    = '0;
      gnt      = 1'b0;
      ready    = 1'b0;
      redir    = 1'b0;
      redir_pc = '0;
      lat      = 1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic wait_insn(input int max_cyc, output bit found);
      found = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         to_neg();
         if (insn_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
         to_next();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; gnt = 1'b0; ready = 1'b0; redir = 1'b0; redir_pc = '0;
      rvalid = 1'b0; rdata = '0;
      #2;
      n_chk++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req); end
      n_chk++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", insn_valid); end
      n_chk++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000000", addr); end
      n_chk++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_pc: got %h expected 00000000", fetch_pc); end
   endtask

   task automatic test_stream();
      do_reset();
      gnt = 1'b1; ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         to_neg();
         n_chk++; if (addr !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_addr c%0d: got %h expected %h", k, addr, 32'(4 * k)); end
         n_chk++; if (insn_valid !== (k >= 2)) begin n_fail++; $display("FAIL stream_valid c%0d: got %b expected %b", k, insn_valid, (k >= 2)); end
         if (k >= 2) begin
            n_chk++; if (insn_pc !== 32'(4 * (k - 2))) begin n_fail++; $display("FAIL stream_pc c%0d: got %h expected %h", k, insn_pc, 32'(4 * (k - 2))); end
            n_chk++; if (insn !== dat(32'(4 * (k - 2)))) begin n_fail++; $display("FAIL stream_insn c%0d: got %h expected %h", k, insn, dat(32'(4 * (k - 2)))); end
         end
         to_next();
      end
   endtask

   task automatic test_backpressure();
      int grants;
      grants = 0;
      do_reset();
      gnt = 1'b1; ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         to_neg();
         if (req === 1'b1 && gnt === 1'b1) grants++;
         if (k >= 4) begin
            n_chk++; if (req !== 1'b0) begin n_fail++; $display("FAIL bp_req_low c%0d: got %b expected 0", k, req); end
            n_chk++; if (addr !== 32'h10) begin n_fail++; $display("FAIL bp_addr_hold c%0d: got %h expected 00000010", k, addr); end
         end
         to_next();
      end
      n_chk++; if (grants !== 4) begin n_fail++; $display("FAIL bp_grants: got %0d expected 4", grants); end
      ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         to_neg();
         n_chk++; if (insn_valid !== 1'b1 || insn_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL bp_drain %0d: got valid=%b pc=%h expected valid=1 pc=%h", i, insn_valid, insn_pc, 32'(4 * i)); end
         if (i == 0) begin
            n_chk++; if (req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req: got %b expected 0", req); end
         end
         if (i == 1) begin
            n_chk++; if (req !== 1'b1 || addr !== 32'h10) begin n_fail++; $display("FAIL bp_resume: got req=%b addr=%h expected req=1 addr=00000010", req, addr); end
         end
         to_next();
      end
   endtask

   task automatic test_redirect();
      bit found;
      do_reset();
      gnt = 1'b1; ready = 1'b0; lat = 1;
      to_neg(); to_next();
      to_neg(); to_next();
      lat = 6;
      to_neg(); to_next();
      to_neg();
      n_chk++; if (insn_valid !== 1'b1 || insn_pc !== 32'h0) begin n_fail++; $display("FAIL redir_pre: got valid=%b pc=%h expected valid=1 pc=00000000", insn_valid, insn_pc); end
      to_next();
      redir = 1'b1; redir_pc = 32'h0000_0103;
      to_neg();
      n_chk++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid_mask: got %b expected 0", insn_valid); end
      n_chk++; if (req !== 1'b0) begin n_fail++; $display("FAIL redir_req_mask: got %b expected 0", req); end
      to_next();
      redir = 1'b0; ready = 1'b1; lat = 1;
      to_neg();
      n_chk++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b expected 0", insn_valid); end
      n_chk++; if (addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got %h expected 00000100", addr); end
      n_chk++; if (fetch_pc !== 32'h100) begin n_fail++; $display("FAIL redir_fetch_pc: got %h expected 00000100", fetch_pc); end
      n_chk++; if (req !== 1'b1) begin n_fail++; $display("FAIL redir_req: got %b expected 1", req); end
      to_next();
      wait_insn(20, found);
      n_chk++;
      if (!found) begin n_fail++; $display("FAIL redir_first timeout: got no insn expected pc 00000100"); end
      else if (insn_pc !== 32'h100 || insn !== dat(32'h100)) begin n_fail++; $display("FAIL redir_first: got pc=%h insn=%h expected pc=00000100 insn=%h", insn_pc, insn, dat(32'h100)); end
      if (found) to_next();
      wait_insn(5, found);
      n_chk++;
      if (!found || insn_pc !== 32'h104) begin n_fail++; $display("FAIL redir_second: got found=%b pc=%h expected pc=00000104", found, insn_pc); end
      if (found) to_next();
   endtask

   task automatic test_gnt_stall();
      do_reset();
      gnt = 1'b0; ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         to_neg();
         n_chk++; if (req !== 1'b1 || addr !== 32'h0 || fetch_pc !== 32'h0) begin n_fail++; $display("FAIL stall c%0d: got req=%b addr=%h fpc=%h expected req=1 addr=0 fpc=0", k, req, addr, fetch_pc); end
         n_chk++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid c%0d: got %b expected 0", k, insn_valid); end
         to_next();
      end
      gnt = 1'b1;
      to_neg(); to_next();
      to_neg();
      n_chk++; if (addr !== 32'h4) begin n_fail++; $display("FAIL stall_release: got %h expected 00000004", addr); end
      to_next();
   endtask

   task automatic test_redirect_collide();
      bit found;
      do_reset();
      gnt = 1'b1; ready = 1'b1; lat = 2;
      for (int k = 0; k < 5; k++) begin
         to_neg(); to_next();
      end
      redir = 1'b1; redir_pc = 32'h0000_0200;
      to_neg();
      n_chk++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL coll_valid: got %b expected 0", insn_valid); end
      n_chk++; if (req !== 1'b0) begin n_fail++; $display("FAIL coll_req: got %b expected 0", req); end
      to_next();
      redir = 1'b0;
      to_neg();
      n_chk++; if (insn_valid !== 1'b0 || addr !== 32'h200) begin n_fail++; $display("FAIL coll_after: got valid=%b addr=%h expected valid=0 addr=00000200", insn_valid, addr); end
      to_next();
      wait_insn(20, found);
      n_chk++;
      if (!found || insn_pc !== 32'h200 || insn !== dat(32'h200)) begin n_fail++; $display("FAIL coll_first: got found=%b pc=%h insn=%h expected pc=00000200 insn=%h", found, insn_pc, insn, dat(32'h200)); end
      if (found) to_next();
      wait_insn(5, found);
      n_chk++;
      if (!found || insn_pc !== 32'h204 || insn !== dat(32'h204)) begin n_fail++; $display("FAIL coll_second: got found=%b pc=%h insn=%h expected pc=00000204 insn=%h", found, insn_pc, insn, dat(32'h204)); end
      if (found) to_next();
   endtask

   task automatic test_wrap();
      bit found;
      do_reset();
      gnt = 1'b0; redir = 1'b1; redir_pc = 32'hFFFF_FFFF;
      to_neg(); to_next();
      redir = 1'b0; gnt = 1'b1; ready = 1'b1;
      to_neg();
      n_chk++; if (addr !== 32'hFFFF_FFFC || req !== 1'b1) begin n_fail++; $display("FAIL wrap_align: got req=%b addr=%h expected req=1 addr=fffffffc", req, addr); end
      to_next();
      to_neg();
      n_chk++; if (addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 00000000", addr); end
      to_next();
      wait_insn(10, found);
      n_chk++;
      if (!found || insn_pc !== 32'hFFFF_FFFC || insn !== dat(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_first: got found=%b pc=%h insn=%h expected pc=fffffffc", found, insn_pc, insn); end
      if (found) to_next();
      wait_insn(5, found);
      n_chk++;
      if (!found || insn_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_second: got found=%b pc=%h expected pc=00000000", found, insn_pc); end
      if (found) to_next();
   endtask

   task automatic test_async_reset();
      bit found;
      do_reset();
      gnt = 1'b1; ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         to_neg(); to_next();
      end
      #3;
      rst_n = 1'b0;
      pend_addr.delete();
      pend_due.delete();
      rvalid = 1'b0;
      #1;
      n_chk++; if (req !== 1'b0) begin n_fail++; $display("FAIL arst_req: got %b expected 0", req); end
      n_chk++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", insn_valid); end
      n_chk++; if (addr !== 32'h0 || fetch_pc !== 32'h0) begin n_fail++; $display("FAIL arst_pc: got addr=%h fpc=%h expected 0", addr, fetch_pc); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      drive_mem();
      to_neg();
      n_chk++; if (req !== 1'b1 || addr !== 32'h0) begin n_fail++; $display("FAIL arst_restart: got req=%b addr=%h expected req=1 addr=0", req, addr); end
      to_next();
      wait_insn(10, found);
      n_chk++;
      if (!found || insn_pc !== 32'h0 || insn !== dat(32'h0)) begin n_fail++; $display("FAIL arst_first: got found=%b pc=%h insn=%h expected pc=00000000", found, insn_pc, insn); end
      if (found) to_next();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_gnt_stall();
      test_redirect_collide();
      test_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
